// File: rtl/rambus_pkg.sv
// Shared types and widths for the rambus SRAM responder.
package rambus_pkg;

    localparam int unsigned RAMBUS_ADDR_W      = 10;
    localparam int unsigned RAMBUS_DATA_W      = 32;
    localparam int unsigned RAMBUS_SEL_W       = 4;
    localparam int unsigned RAMBUS_IDX_W       = 8;
    localparam int unsigned RAMBUS_CNT_W       = 4;
    localparam int unsigned RAMBUS_WAIT_STATES = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } rambus_state_e;

    // Replace the byte lanes of old_w selected by sel with those of new_w.
    function automatic logic [RAMBUS_DATA_W-1:0] rambus_merge(
        input logic [RAMBUS_DATA_W-1:0] old_w,
        input logic [RAMBUS_DATA_W-1:0] new_w,
        input logic [RAMBUS_SEL_W-1:0]  sel
    );
        logic [RAMBUS_DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < int'(RAMBUS_SEL_W); b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rambus_sram_array.sv
// Single-port DEPTH x 32 word array with per-byte write enable and registered read data.
module rambus_sram_array
    import rambus_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [RAMBUS_SEL_W-1:0]  sel_i,
    input  logic [RAMBUS_IDX_W-1:0]  idx_i,
    input  logic [RAMBUS_DATA_W-1:0] wdat_i,
    output logic [RAMBUS_DATA_W-1:0] rdat_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [RAMBUS_DATA_W-1:0] mem [DEPTH];
    logic [RAMBUS_DATA_W-1:0] rd_d;
    logic [RAMBUS_DATA_W-1:0] rd_q;
    logic [AW-1:0]            row_c;
    logic                     unused_idx_c;

    // Word index wraps modulo DEPTH; upper index bits are intentionally dropped.
    assign row_c        = idx_i[AW-1:0];
    assign unused_idx_c = ^idx_i;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem[row_c] <= rambus_merge(mem[row_c], wdat_i, sel_i);
        end
    end

    // Read data only changes on a read access; writes leave it alone.
    always_comb begin
        rd_d = rd_q;
        if (en_i && !we_i) begin
            rd_d = mem[row_c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rdat_o = rd_q;

endmodule

// File: rtl/rambus_sram_responder.sv
// Wishbone SRAM responder: captures a single-word request, waits WAIT_STATES cycles, accesses the array, acks.
module rambus_sram_responder
    import rambus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = RAMBUS_WAIT_STATES,
    parameter int unsigned DEPTH       = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_we_i,
    input  logic [RAMBUS_SEL_W-1:0]  wb_sel_i,
    input  logic [RAMBUS_DATA_W-1:0] wb_dat_i,
    input  logic [RAMBUS_ADDR_W-1:0] wb_addr_i,
    output logic                     wb_ack_o,
    output logic [RAMBUS_DATA_W-1:0] wb_dat_o,
    output logic                     busy_o
);

    rambus_state_e            state_q, state_d;
    logic [RAMBUS_CNT_W-1:0]  cnt_q, cnt_d;
    logic [RAMBUS_IDX_W-1:0]  idx_q, idx_d;
    logic                     we_q, we_d;
    logic [RAMBUS_SEL_W-1:0]  sel_q, sel_d;
    logic [RAMBUS_DATA_W-1:0] dat_q, dat_d;
    logic                     ack_q, ack_d;
    logic                     access_c;
    logic                     mem_en_c;
    logic                     unused_addr_c;

    assign unused_addr_c = ^wb_addr_i[1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        ack_d    = 1'b0;
        access_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    idx_d   = wb_addr_i[RAMBUS_ADDR_W-1:2];
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    dat_d   = wb_dat_i;
                    cnt_d   = RAMBUS_CNT_W'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - RAMBUS_CNT_W'(1);
                end else begin
                    access_c = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A reset landing on the access edge must suppress the array write.
    assign mem_en_c = access_c & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
        end
    end

    rambus_sram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (mem_en_c),
        .we_i   (we_q),
        .sel_i  (sel_q),
        .idx_i  (idx_q),
        .wdat_i (dat_q),
        .rdat_o (wb_dat_o)
    );

    assign wb_ack_o = ack_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_rambus_sram_responder.sv
// Scoreboard bench: two responders (WAIT_STATES=1 and 0) driven by directed Wishbone vectors.
module tb_rambus_sram_responder;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          cyc;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stb  [2];
    logic        cyc  [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic [31:0] wdat [2];
    logic [9:0]  addr [2];
    logic        ack  [2];
    logic [31:0] dout [2];
    logic        busy [2];

    int   cyc_cnt = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   next_id = 0;
    exp_t q0[$];
    exp_t q1[$];

    rambus_sram_responder #(.WAIT_STATES(1), .DEPTH(256)) dut_a (
        .clk(clk), .reset(rst_n),
        .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_we_i(we[0]), .wb_sel_i(sel[0]),
        .wb_dat_i(wdat[0]), .wb_addr_i(addr[0]),
        .wb_ack_o(ack[0]), .wb_dat_o(dout[0]), .busy_o(busy[0])
    );

    rambus_sram_responder #(.WAIT_STATES(0), .DEPTH(256)) dut_b (
        .clk(clk), .reset(rst_n),
        .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_we_i(we[1]), .wb_sel_i(sel[1]),
        .wb_dat_i(wdat[1]), .wb_addr_i(addr[1]),
        .wb_ack_o(ack[1]), .wb_dat_o(dout[1]), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    function automatic int ws(input int u);
        return (u == 0) ? 1 : 0;
    endfunction

    function automatic void push(input int u, input bit rd, input logic [31:0] d, input int c);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        e.cyc  = c;
        e.id   = next_id;
        next_id++;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Monitor: every ack must match the oldest pending expectation in cycle and data.
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        for (int u = 0; u < 2; u++) begin
            if (ack[u] === 1'b1) begin
                got = 1'b0;
                if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                n_vec++;
                if (!got) begin
                    n_bad++;
                    $display("FAIL unexpected_ack dut%0d cycle %0d: ack=1 required 0", u, cyc_cnt);
                end else begin
                    if (cyc_cnt != e.cyc) begin
                        n_bad++;
                        $display("FAIL ack_cycle dut%0d txn %0d: ack at cycle %0d required %0d",
                                 u, e.id, cyc_cnt, e.cyc);
                    end
                    if (e.rd) begin
                        n_vec++;
                        if (dout[u] !== e.data) begin
                            n_bad++;
                            $display("FAIL read_data dut%0d txn %0d: got %h required %h",
                                     u, e.id, dout[u], e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic idle_bus(input int u);
        stb[u] = 1'b0; cyc[u] = 1'b0; we[u] = 1'b0;
        sel[u] = 4'h0; wdat[u] = '0; addr[u] = '0;
    endtask

    task automatic drive(input int u, input logic w, input logic [9:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        stb[u] = 1'b1; cyc[u] = 1'b1; we[u] = w;
        sel[u] = s; wdat[u] = d; addr[u] = a;
    endtask

    // Returns at the negedge on which ack is seen, or reports a timeout.
    task automatic wait_ack(input int u);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack[u] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout dut%0d: ack=0 required 1 within 40 cycles", u);
        end
    endtask

    task automatic xfer(input int u, input logic w, input logic [9:0] a,
                        input logic [3:0] s, input logic [31:0] d, input logic [31:0] exp_rd);
        @(negedge clk);
        drive(u, w, a, s, d);
        push(u, !w, exp_rd, cyc_cnt + 2 + ws(u));
        wait_ack(u);
        idle_bus(u);
    endtask

    // Write then read with stb/cyc held high; acks must be 3+WAIT_STATES apart.
    task automatic b2b(input int u, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(u, 1'b1, a, 4'hF, d);
        push(u, 1'b0, '0, cyc_cnt + 2 + ws(u));
        wait_ack(u);
        we[u] = 1'b0;
        push(u, 1'b1, d, cyc_cnt + 3 + ws(u));
        wait_ack(u);
        idle_bus(u);
    endtask

    task automatic abort_write(input int u, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(u, 1'b1, a, 4'hF, d);
        @(negedge clk);
        chk("abort_busy_in_wait", 32'(busy[u]), 32'd1);
        idle_bus(u);
        @(negedge clk);
        chk("abort_busy_cleared", 32'(busy[u]), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Reset asserted in the WAIT cycle whose closing edge would perform the write.
    task automatic reset_mid(input int u, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(u, 1'b1, a, 4'hF, d);
        repeat (ws(u) + 1) @(negedge clk);
        chk("rst_busy_before", 32'(busy[u]), 32'd1);
        rst_n = 1'b0;
        idle_bus(u);
        @(negedge clk);
        chk("rst_ack", 32'(ack[u]), 32'd0);
        chk("rst_dat", dout[u], 32'h0);
        chk("rst_busy", 32'(busy[u]), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_bus(0);
        idle_bus(1);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_ack", 32'(ack[u]), 32'd0);
            chk("reset_dat", dout[u], 32'h0);
            chk("reset_busy", 32'(busy[u]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write/read, ack at N+3
        xfer(0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, '0);
        xfer(0, 1'b0, 10'h010, 4'hF, '0, 32'hDEADBEEF);

        // Byte lanes, sel=0 write, read ignores sel
        xfer(0, 1'b1, 10'h020, 4'hF, 32'h11223344, '0);
        xfer(0, 1'b1, 10'h020, 4'b0101, 32'hAABBCCDD, '0);
        xfer(0, 1'b0, 10'h020, 4'hF, '0, 32'h11BB33DD);
        xfer(0, 1'b1, 10'h020, 4'h0, 32'hFFFFFFFF, '0);
        xfer(0, 1'b0, 10'h022, 4'h0, '0, 32'h11BB33DD);

        // Writes leave the read register untouched
        xfer(0, 1'b1, 10'h010, 4'b0011, 32'h00005A5A, '0);
        chk("dat_hold_after_write", dout[0], 32'h11BB33DD);
        xfer(0, 1'b0, 10'h013, 4'hF, '0, 32'hDEAD5A5A);

        // Abort during WAIT
        xfer(0, 1'b1, 10'h030, 4'hF, 32'h0, '0);
        abort_write(0, 10'h030, 32'h00000055);
        xfer(0, 1'b0, 10'h030, 4'hF, '0, 32'h0);

        // Back-to-back at the top word, then alias address
        b2b(0, 10'h3FC, 32'h12345678);
        xfer(0, 1'b0, 10'h3FD, 4'hF, '0, 32'h12345678);

        // Reset mid-write with WAIT_STATES=1
        xfer(0, 1'b1, 10'h040, 4'hF, 32'hCAFEF00D, '0);
        xfer(0, 1'b0, 10'h040, 4'hF, '0, 32'hCAFEF00D);
        reset_mid(0, 10'h040, 32'h99999999);
        xfer(0, 1'b0, 10'h040, 4'hF, '0, 32'hCAFEF00D);

        // WAIT_STATES=0: ack at N+2, back-to-back, reset mid-write
        xfer(1, 1'b1, 10'h008, 4'hF, 32'h0BADCAFE, '0);
        xfer(1, 1'b0, 10'h008, 4'hF, '0, 32'h0BADCAFE);
        b2b(1, 10'h0F0, 32'hA5A5C3C3);
        reset_mid(1, 10'h008, 32'h77777777);
        xfer(1, 1'b0, 10'h008, 4'hF, '0, 32'h0BADCAFE);

        repeat (5) @(negedge clk);
        chk("pending_acks_dut0", 32'(q0.size()), 32'd0);
        chk("pending_acks_dut1", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rambus_sram_responder.md
# rambus_sram_responder

Wishbone responder (slave) terminating the CPU's SRAM bus (the `rambus_wb_*` master port): accepts single-word read/write cycles with byte selects and answers with a registered `ack` after a programmable number of wait states. It backs the data/code memory of the oak8m core in simulation and in FPGA builds, and it stands in place of the OpenRAM macro wrapper. Storage is an internal byte-lane-writable word array.

## Interface
- `WAIT_STATES`, default 1: extra cycles inserted between request capture and array access (0–15).
- `DEPTH`, default 256: number of 32-bit words; must be a power of two ≤ 256.
- `clk`  in  1  system clock; the same clock the master exports as `rambus_wb_clk_o`.
- `reset`  in  1  synchronous, active-low reset.
- `wb_stb_i`  in  1  strobe.
- `wb_cyc_i`  in  1  cycle valid.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_sel_i`  in  4  byte-lane enables; bit n covers data bits [8n+7:8n].
- `wb_dat_i`  in  32  write data.
- `wb_addr_i`  in  10  byte address; word index = `wb_addr_i[9:2]` modulo `DEPTH`; bits [1:0] are ignored.
- `wb_ack_o`  out  1  one-cycle completion pulse.
- `wb_dat_o`  out  32  read data; valid while `wb_ack_o` is high for a read.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: if `wb_cyc_i & wb_stb_i`, latch addr/we/sel/dat, load wait counter with `WAIT_STATES`, go to WAIT.
- WAIT: if `wb_cyc_i` is low, abort: go to IDLE with no array access and no ack. Else if counter ≠ 0, decrement it. Else perform the access on this edge and go to ACK.
  - Write: update each byte lane whose `sel` bit is set; others are unchanged. `sel` = 0 still completes and acks.
  - Read: `wb_dat_o` ← full word, regardless of `sel`.
- ACK: `wb_ack_o` = 1 for exactly this cycle, then IDLE unconditionally. A write committed in WAIT stays committed even if `cyc` drops during ACK.
- Back-to-back: if `stb & cyc` are still high in the first IDLE cycle after ACK, that is a new transaction. The master must deassert `stb` or change the request in the cycle after it sees ack.
- `wb_dat_o` holds its value until the next read access. Writes do not change it.
- Request inputs are sampled only in IDLE. Changes during WAIT/ACK are ignored.
- Reset (`reset` = 0): state IDLE, counter 0, `wb_ack_o` 0, `wb_dat_o` 0, `busy_o` 0. Array contents are not reset.
- Reset mid-transaction: no ack is issued. A write whose access edge had not occurred is not performed.

## Timing
- `stb` first sampled high at the end of cycle N → `wb_ack_o` high in cycle N+2+`WAIT_STATES` (WAIT_STATES=0 → ack in N+2; default → N+3).
- Array access occurs on the edge ending the last WAIT cycle. Read data is registered with the same edge, so it is aligned with ack.
- Throughput: one transaction per 3+`WAIT_STATES` cycles when requests are back-to-back.
- Write-then-read to the same word: the read returns the new data, since the write commits before the read is captured.
- All outputs come from registers or from a decode of the state register (`busy_o`). There is no combinational input→output path.

## Structure
- Shared package `rambus_pkg`:
  - FSM state enum (IDLE/WAIT/ACK);
  - `RAMBUS_ADDR_W` = 10, `RAMBUS_DATA_W` = 32, `RAMBUS_SEL_W` = 4;
  - default `WAIT_STATES`.
- One sub-module: `rambus_sram_array`, a single-port `DEPTH`×32 array with a per-byte write enable and a registered read port. The FSM, counter and handshake stay in the top module.

## Test plan
- WAIT_STATES=1: write 0xDEADBEEF to addr 0x010 with sel=4'hF → ack in cycle N+3 for one cycle only. Read of 0x010 → `wb_dat_o` = 0xDEADBEEF with ack.
- Byte lanes: preload 0x11223344 at 0x020. Write 0xAABBCCDD with sel=4'b0101 → read returns 0x11BB33DD. Write with sel=0 → acked, word unchanged.
- Abort: start a write of 0x55 to 0x030 (old value 0), drop `cyc` during WAIT → no ack, `busy_o` returns to 0, read of 0x030 returns 0.
- Back-to-back: hold `stb`/`cyc` high across a write of 0x12345678 to 0x3FC followed by a read of 0x3FC → two acks spaced 3+WAIT_STATES cycles apart, read returns 0x12345678. Address 0x3FD aliases to the same word.
- Reset: assert `reset`=0 in the WAIT cycle of a write → no ack, `wb_dat_o`=0, `busy_o`=0, target word unchanged. Repeat with WAIT_STATES=0 → ack in N+2.
